step_resp_checker: RTL

- Synthesizable, emulator-side successor to the single-channel RC step-test controller.
- Applies a step stimulus to N_CH analog-model channels (fixed-point, svreal-style packed signed).
- Samples all model outputs coherently every DT_TICKS emulator cycles for N_STEPS samples, and compares each against an externally supplied expected-value table with absolute tolerance.
- Counts errors and reports pass/fail, so the check runs on-FPGA with no host-side per-sample polling.

---
 rtl/step_resp_checker_pkg.sv | 40 ++++
 rtl/step_resp_checker_if.sv | 15 +
 rtl/step_resp_checker_tol_cmp.sv | 18 +
 rtl/step_resp_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/step_resp_checker_pkg.sv
// Shared types and width helpers for the step-response checker and the
// reusable comparison blocks that sit next to it.
package step_resp_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SAMPLE  = 3'd1,
        S_CMP_REQ = 3'd2,
        S_CMP_CHK = 3'd3,
        S_WAIT    = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // $clog2 that never yields a zero-width vector
    function automatic int clog2_min1(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

    // expected-table address width (step*N_CH + ch)
    function automatic int addr_w(input int n_steps, input int n_ch);
        return clog2_min1(n_steps * n_ch);
    endfunction

    // error counter width, able to hold every possible mismatch
    function automatic int count_w(input int n_steps, input int n_ch);
        return clog2_min1(n_steps * n_ch + 1);
    endfunction

    function automatic int step_w(input int n_steps);
        return clog2_min1(n_steps);
    endfunction

    function automatic int ch_w(input int n_ch);
        return clog2_min1(n_ch);
    endfunction

endpackage

// File: rtl/step_resp_checker_if.sv
// Expected-value table port: the checker issues a read strobe and address,
// the table answers with data exactly one cycle later.
interface step_resp_checker_if
    import step_resp_pkg::*;
#(
    parameter int ADDR_W = addr_w(25, 2),
    parameter int WIDTH  = 16
);
    logic                     exp_rd;
    logic [ADDR_W-1:0]        exp_addr;
    logic signed [WIDTH-1:0]  exp_data;

    modport master (output exp_rd, output exp_addr, input exp_data);
    modport slave  (input exp_rd, input exp_addr, output exp_data);
endinterface

// File: rtl/step_resp_checker_tol_cmp.sv
// Combinational absolute-difference tolerance check between two signed
// fixed-point words. One extra bit on the subtract keeps the extremes
// (e.g. -32768 vs 32767) from wrapping into a false pass.
module tol_cmp #(
    parameter int WIDTH   = 16,
    parameter int ABS_TOL = 4
)(
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic                    o_within_tol
);
    logic signed [WIDTH:0] w_diff;
    logic        [WIDTH:0] w_abs;

    assign w_diff       = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
    assign w_abs        = w_diff[WIDTH] ? (~w_diff + 1'b1) : w_diff;
    assign o_within_tol = (w_abs <= (WIDTH+1)'(ABS_TOL));
endmodule

// File: rtl/step_resp_checker.sv
// Multi-channel step-response checker: drives a step into N_CH analog
// models, snapshots all outputs every DT_TICKS cycles and compares each
// channel against an external expected table with absolute tolerance.
module step_resp_checker
    import step_resp_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int WIDTH    = 16,
    parameter int N_STEPS  = 25,
    parameter int DT_TICKS = 10,
    parameter int ABS_TOL  = 4
)(
    input  logic                           emu_clk,
    input  logic                           emu_rst,
    input  logic                           start,
    input  logic [N_CH*WIDTH-1:0]          amp,
    input  logic [N_CH*WIDTH-1:0]          v_out,
    output logic [N_CH*WIDTH-1:0]          v_in,
    step_resp_checker_if.master            exp_if,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [count_w(N_STEPS,N_CH)-1:0] err_count,
    output logic [step_w(N_STEPS)-1:0]     first_err_step,
    output logic [ch_w(N_CH)-1:0]          first_err_ch,
    output logic [step_w(N_STEPS)-1:0]     sample_step
);
    localparam int ADDR_W = addr_w(N_STEPS, N_CH);
    localparam int CNT_W  = count_w(N_STEPS, N_CH);
    localparam int STEP_W = step_w(N_STEPS);
    localparam int CH_W   = ch_w(N_CH);
    localparam int TMR_W  = clog2_min1(DT_TICKS);

    // the compare loop for one sample must fit inside one sample period
    if (DT_TICKS < 2*N_CH + 2) begin : g_bad_dt
        $error("step_resp_checker: DT_TICKS must be >= 2*N_CH+2");
    end
    if (ABS_TOL < 0 || ABS_TOL >= 2**(WIDTH-1)) begin : g_bad_tol
        $error("step_resp_checker: ABS_TOL out of range");
    end

    state_t                   r_state;
    logic [TMR_W-1:0]         r_timer;
    logic [STEP_W-1:0]        r_step;
    logic [CH_W-1:0]          r_ch;
    logic [N_CH*WIDTH-1:0]    r_v_in;
    logic                     r_exp_rd;
    logic [ADDR_W-1:0]        r_exp_addr;
    logic                     r_done;
    logic                     r_pass;
    logic [CNT_W-1:0]         r_err_count;
    logic [STEP_W-1:0]        r_first_err_step;
    logic [CH_W-1:0]          r_first_err_ch;

    logic signed [WIDTH-1:0]  w_snap [N_CH];
    logic                     w_start_ok;
    logic                     w_timer_end;
    logic                     w_enter_sample;
    logic                     w_within;
    logic                     w_last_ch;
    logic                     w_last_step;
    logic [ADDR_W-1:0]        w_base_addr;

    assign w_start_ok     = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_timer_end    = (r_timer == TMR_W'(DT_TICKS - 1));
    assign w_enter_sample = w_start_ok || (r_state == S_WAIT && w_timer_end);
    assign w_last_ch      = (r_ch == CH_W'(N_CH - 1));
    assign w_last_step    = (r_step == STEP_W'(N_STEPS - 1));
    assign w_base_addr    = ADDR_W'(32'(r_step) * N_CH);

    // per-channel snapshot registers, all loaded in the same SAMPLE cycle
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic signed [WIDTH-1:0] r_snap;

        // capture this channel's model output coherently with the others
        always_ff @(posedge emu_clk or posedge emu_rst) begin
            if (emu_rst) begin
                r_snap <= '0;
            end else if (r_state == S_SAMPLE) begin
                r_snap <= v_out[gi*WIDTH +: WIDTH];
            end
        end

        assign w_snap[gi] = r_snap;
    end

    tol_cmp #(
        .WIDTH   (WIDTH),
        .ABS_TOL (ABS_TOL)
    ) u_tol_cmp (
        .i_a          (w_snap[r_ch]),
        .i_b          (exp_if.exp_data),
        .o_within_tol (w_within)
    );

    // sample timer: zero in every SAMPLE cycle, free-running otherwise
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            r_timer <= '0;
        end else if (w_enter_sample) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // run sequencing, table requests and error bookkeeping
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            r_state          <= S_IDLE;
            r_step           <= '0;
            r_ch             <= '0;
            r_v_in           <= '0;
            r_exp_rd         <= 1'b0;
            r_exp_addr       <= '0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= '0;
            r_first_err_step <= '0;
            r_first_err_ch   <= '0;
        end else begin
            r_exp_rd <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_v_in           <= amp;
                        r_err_count      <= '0;
                        r_first_err_step <= '0;
                        r_first_err_ch   <= '0;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_step           <= '0;
                        r_state          <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_ch       <= '0;
                    r_exp_rd   <= 1'b1;
                    r_exp_addr <= w_base_addr;
                    r_state    <= S_CMP_REQ;
                end
                S_CMP_REQ: begin
                    r_state <= S_CMP_CHK;
                end
                S_CMP_CHK: begin
                    if (!w_within) begin
                        if (!(&r_err_count)) begin
                            r_err_count <= r_err_count + CNT_W'(1);
                        end
                        if (r_err_count == '0) begin
                            r_first_err_step <= r_step;
                            r_first_err_ch   <= r_ch;
                        end
                    end
                    if (!w_last_ch) begin
                        r_ch       <= r_ch + CH_W'(1);
                        r_exp_rd   <= 1'b1;
                        r_exp_addr <= r_exp_addr + ADDR_W'(1);
                        r_state    <= S_CMP_REQ;
                    end else if (w_last_step) begin
                        r_done  <= 1'b1;
                        r_pass  <= (r_err_count == '0) && w_within;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_timer_end) begin
                        r_step  <= r_step + STEP_W'(1);
                        r_state <= S_SAMPLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy            = (r_state == S_SAMPLE) || (r_state == S_CMP_REQ) ||
                             (r_state == S_CMP_CHK) || (r_state == S_WAIT);
    assign v_in            = r_v_in;
    assign exp_if.exp_rd   = r_exp_rd;
    assign exp_if.exp_addr = r_exp_addr;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_step  = r_first_err_step;
    assign first_err_ch    = r_first_err_ch;
    assign sample_step     = r_step;
endmodule
